// File: rtl/fft_pkg.sv
// Shared constants and sample types for the 64-point FFT datapath and the
// spectral blocks placed downstream of it.
package fft_pkg;

    localparam int FFT_N     = 64;
    localparam int FFT_LOG2N = 6;
    localparam int FFT_OUT_W = 17;
    localparam int FFT_MAG_W = 2 * FFT_OUT_W;

    typedef struct packed {
        logic signed [FFT_OUT_W-1:0] re;
        logic signed [FFT_OUT_W-1:0] im;
    } fft_cplx_t;

endpackage

// File: rtl/fft_peak_finder_mag_sq.sv
// Two-stage pipelined |x|^2 = re^2 + im^2 with the valid flag and a bin tag
// carried alongside the data.
module mag_sq #(
    parameter int DW = 17,
    parameter int BW = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [BW-1:0]        in_bin,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    output logic [BW-1:0]        out_bin,
    output logic [2*DW-1:0]      out_mag
);

    localparam int MW = 2 * DW;

    // Sign-extend to the full product width first, so the multiply is done at MW bits.
    logic signed [MW-1:0] re_x, im_x, re_p, im_p;
    assign re_x = MW'(in_re);
    assign im_x = MW'(in_im);
    assign re_p = re_x * re_x;
    assign im_p = im_x * im_x;

    logic          v1;
    logic [BW-1:0] bin1;
    logic [MW-1:0] re_sq, im_sq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            bin1  <= '0;
            re_sq <= '0;
            im_sq <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                bin1  <= in_bin;
                re_sq <= unsigned'(re_p);
                im_sq <= unsigned'(im_p);
            end
        end
    end

    // Each square is at most 2^(2DW-2), so the sum fits in MW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_mag   <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                out_bin <= bin1;
                out_mag <= re_sq + im_sq;
            end
        end
    end

endmodule

// File: rtl/fft_peak_finder.sv
// Streaming per-frame peak detector on the FFT bin stream: magnitude stream
// out, plus index/magnitude of the largest bin and a threshold flag per frame.
module fft_peak_finder
    import fft_pkg::*;
#(
    parameter int DW      = FFT_OUT_W,
    parameter int LOG2N   = FFT_LOG2N,
    parameter int SKIP_DC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_en,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    input  logic [2*DW-1:0]      threshold,
    output logic                 mag_valid,
    output logic [LOG2N-1:0]     mag_bin,
    output logic [2*DW-1:0]      mag_out,
    output logic                 peak_valid,
    output logic [LOG2N-1:0]     peak_bin,
    output logic [2*DW-1:0]      peak_mag,
    output logic                 peak_hit
);

    localparam int MW = 2 * DW;
    localparam logic [LOG2N-1:0] LAST_BIN = '1;

    // Handshake: in_en is valid-only with no back-pressure; every cycle with
    // in_en=1 is exactly one bin, and every *_valid output is a one-cycle strobe.
    logic [LOG2N-1:0]     bin_cnt;
    logic                 in_v_q;
    logic [LOG2N-1:0]     in_bin_q;
    logic signed [DW-1:0] in_re_q, in_im_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt  <= '0;
            in_v_q   <= 1'b0;
            in_bin_q <= '0;
            in_re_q  <= '0;
            in_im_q  <= '0;
        end else begin
            in_v_q <= in_en;
            if (in_en) begin
                bin_cnt  <= bin_cnt + 1'b1;
                in_bin_q <= bin_cnt;
                in_re_q  <= in_re;
                in_im_q  <= in_im;
            end
        end
    end

    mag_sq #(
        .DW (DW),
        .BW (LOG2N)
    ) u_mag_sq (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_v_q),
        .in_bin    (in_bin_q),
        .in_re     (in_re_q),
        .in_im     (in_im_q),
        .out_valid (mag_valid),
        .out_bin   (mag_bin),
        .out_mag   (mag_out)
    );

    logic [MW-1:0]    max_mag, cand_mag;
    logic [LOG2N-1:0] max_bin, cand_bin;
    logic             take;

    // Strict compare: on a tie the earlier (lower) bin is kept.
    always_comb begin
        take     = mag_out > max_mag;
        cand_mag = max_mag;
        cand_bin = max_bin;
        if (take) begin
            cand_mag = mag_out;
            cand_bin = mag_bin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_mag    <= '0;
            max_bin    <= '0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            peak_hit   <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            if (mag_valid) begin
                // Bin 0 reloads instead of comparing, so no state leaks across frames.
                if (mag_bin == '0) begin
                    max_mag <= (SKIP_DC != 0) ? '0 : mag_out;
                    max_bin <= '0;
                end else begin
                    max_mag <= cand_mag;
                    max_bin <= cand_bin;
                end
                if (mag_bin == LAST_BIN) begin
                    peak_bin   <= cand_bin;
                    peak_mag   <= cand_mag;
                    peak_hit   <= cand_mag > threshold;
                    peak_valid <= 1'b1;
                end
            end
        end
    end

endmodule
